// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush controller for the five-stage in-order pipeline,
//               with wrong-path fetch squashing and a stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wait,
    input  logic             d_wait,
    input  logic             ex_busy,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_redirect,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             redirect_take,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_SQUASH = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_mem_hold;
    logic w_ex_hold;
    logic w_lu_match;
    logic w_lu_hold;
    logic w_take;
    logic w_if_hold;
    logic w_squash;

    assign w_squash   = (r_state == c_ST_SQUASH);
    assign w_mem_hold = d_wait;
    assign w_ex_hold  = ex_busy & ~w_mem_hold;
    assign w_lu_match = ex_is_load & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));
    // While squashing, ID only ever holds a bubble, so it cannot create a load-use hazard.
    assign w_lu_hold  = w_lu_match & ~w_mem_hold & ~w_ex_hold & ~w_squash;
    assign w_take     = ex_redirect & ~w_mem_hold & ~w_ex_hold;
    assign w_if_hold  = i_wait & ~w_mem_hold & ~w_ex_hold & ~w_lu_hold & ~w_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_ST_RUN) begin
            if (w_take && i_wait) begin
                w_state_nxt = c_ST_SQUASH;
            end
        end else begin
            if (!w_take && !i_wait) begin
                w_state_nxt = c_ST_RUN;
            end
        end
    end

    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        stall_w       = 1'b0;
        flush_d       = 1'b1;
        flush_e       = 1'b1;
        flush_m       = 1'b1;
        flush_w       = 1'b1;
        redirect_take = 1'b0;
        if (!reset) begin
            stall_f       = w_mem_hold | w_ex_hold | (w_lu_hold & ~w_take) | w_if_hold;
            // A squashing ID stage is flushed every cycle, so it must never also be held.
            stall_d       = (w_mem_hold | w_ex_hold | (w_lu_hold & ~w_take)) & ~w_squash;
            stall_e       = w_mem_hold | w_ex_hold;
            stall_m       = w_mem_hold;
            flush_d       = w_take | w_if_hold | w_squash;
            flush_e       = w_take | w_lu_hold;
            flush_m       = w_ex_hold;
            flush_w       = w_mem_hold;
            redirect_take = w_take;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (stall_f && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl: vector table,
//               directed multi-cycle sequences and random vs. reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_wait, d_wait, ex_busy, ex_is_load, ex_redirect;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;

    logic       sf, sd, se, sm, sw, fd, fe, fm, fw, tk;
    logic       sf_s, sd_s, se_s, sm_s, sw_s, fd_s, fe_s, fm_s, fw_s, tk_s;
    logic [31:0] cnt;
    logic [3:0]  cnt_s;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait),
        .ex_busy(ex_busy), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_redirect(ex_redirect),
        .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm), .stall_w(sw),
        .flush_d(fd), .flush_e(fe), .flush_m(fm), .flush_w(fw),
        .redirect_take(tk), .stall_cycles(cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait),
        .ex_busy(ex_busy), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_redirect(ex_redirect),
        .stall_f(sf_s), .stall_d(sd_s), .stall_e(se_s), .stall_m(sm_s), .stall_w(sw_s),
        .flush_d(fd_s), .flush_e(fe_s), .flush_m(fm_s), .flush_w(fw_s),
        .redirect_take(tk_s), .stall_cycles(cnt_s)
    );

    // Output vector: {stall_f,stall_d,stall_e,stall_m,stall_w,flush_d,flush_e,flush_m,flush_w,take}
    logic [9:0] w_out, w_out_s;
    assign w_out   = {sf, sd, se, sm, sw, fd, fe, fm, fw, tk};
    assign w_out_s = {sf_s, sd_s, se_s, sm_s, sw_s, fd_s, fe_s, fm_s, fw_s, tk_s};

    localparam logic [9:0] c_IDLE  = 10'b0000000000;
    localparam logic [9:0] c_RST   = 10'b0000011110;
    localparam logic [9:0] c_MEM   = 10'b1111000010;
    localparam logic [9:0] c_EXB   = 10'b1110000100;
    localparam logic [9:0] c_LU    = 10'b1100001000;
    localparam logic [9:0] c_IF    = 10'b1000010000;
    localparam logic [9:0] c_TAKE  = 10'b0000011001;
    localparam logic [9:0] c_SQEND = 10'b0000010000;

    typedef struct {
        string      name;
        logic       iw, dw, eb, ld;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, rdr;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[15];

    // Reference model state
    bit          m_sq;
    logic [31:0] m_cnt;
    int          m_cnt_s;
    int          n_cmp;
    int          n_err;

    function automatic vec_t mk(string nm, logic iw, logic dw, logic eb, logic ld,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic rdr, logic [9:0] exp);
        vec_t v;
        v.name = nm; v.iw = iw; v.dw = dw; v.eb = eb; v.ld = ld;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rdr = rdr;
        v.exp = exp;
        return v;
    endfunction

    // Priority chain read straight off the hazard rules.
    function automatic logic [9:0] model_out();
        logic s_f, s_d, s_e, s_m, f_d, f_e, f_m, f_w, t;
        logic lu;
        {s_f, s_d, s_e, s_m, f_d, f_e, f_m, f_w, t} = '0;
        lu = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (reset) begin
            {f_d, f_e, f_m, f_w} = 4'b1111;
        end else begin
            if (d_wait)                begin s_f = 1; s_d = 1; s_e = 1; s_m = 1; f_w = 1; end
            else if (ex_busy)          begin s_f = 1; s_d = 1; s_e = 1; f_m = 1; end
            else if (ex_redirect)      begin t = 1; f_d = 1; f_e = 1; end
            else if (lu && !m_sq)      begin s_f = 1; s_d = 1; f_e = 1; end
            else if (i_wait)           begin s_f = 1; f_d = 1; end
            if (m_sq) begin s_d = 0; f_d = 1; end
        end
        return {s_f, s_d, s_e, s_m, 1'b0, f_d, f_e, f_m, f_w, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iw, input logic dw, input logic eb, input logic ld,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic rdr);
        i_wait = iw; d_wait = dw; ex_busy = eb; ex_is_load = ld;
        ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; ex_redirect = rdr;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle(input string nm, input bit use_want, input logic [9:0] want);
        logic [9:0] m;
        logic [9:0] exp;
        @(negedge clk);
        m   = model_out();
        exp = use_want ? want : m;
        chk(nm, {22'd0, w_out}, {22'd0, exp});
        chk({nm, "_s"}, {22'd0, w_out_s}, {22'd0, exp});
        chk({nm, "_excl"}, {28'd0, w_out[8:5] & w_out[4:1]}, 32'd0);
        chk({nm, "_cnt"}, cnt, m_cnt);
        chk({nm, "_cnt4"}, {28'd0, cnt_s}, m_cnt_s);
        if (reset) begin
            m_sq = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (m[9]) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
            end
            if (m[0] && i_wait)                m_sq = 1;
            else if (m_sq && !m[0] && !i_wait) m_sq = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset", 1, c_RST);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_sq = 0; m_cnt = 0; m_cnt_s = 0;
        tbl[0]  = mk("idle",       0,0,0,0, 0,0,0, 0,0,0, c_IDLE);
        tbl[1]  = mk("lu_rs1",     0,0,0,1, 5,5,0, 1,0,0, c_LU);
        tbl[2]  = mk("lu_rd0",     0,0,0,1, 0,0,0, 1,1,0, c_IDLE);
        tbl[3]  = mk("lu_rs2",     0,0,0,1, 7,1,7, 0,1,0, c_LU);
        tbl[4]  = mk("lu_unused",  0,0,0,1, 5,5,5, 0,0,0, c_IDLE);
        tbl[5]  = mk("lu_noload",  0,0,0,0, 5,5,0, 1,0,0, c_IDLE);
        tbl[6]  = mk("mem",        0,1,0,0, 0,0,0, 0,0,0, c_MEM);
        tbl[7]  = mk("exbusy",     0,0,1,0, 0,0,0, 0,0,0, c_EXB);
        tbl[8]  = mk("ifwait",     1,0,0,0, 0,0,0, 0,0,0, c_IF);
        tbl[9]  = mk("redir",      0,0,0,0, 0,0,0, 0,0,1, c_TAKE);
        tbl[10] = mk("redir_lu",   0,0,0,1, 3,3,0, 1,0,1, c_TAKE);
        tbl[11] = mk("redir_mem",  0,1,0,0, 0,0,0, 0,0,1, c_MEM);
        tbl[12] = mk("redir_exb",  0,0,1,0, 0,0,0, 0,0,1, c_EXB);
        tbl[13] = mk("mem_exb",    1,1,1,1, 4,4,4, 1,1,1, c_MEM);
        tbl[14] = mk("if_lu",      1,0,0,1, 9,0,9, 0,1,0, c_LU);

        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].iw, tbl[i].dw, tbl[i].eb, tbl[i].ld, tbl[i].rd,
                   tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rdr);
            cycle(tbl[i].name, 1, tbl[i].exp);
            do_reset();
        end

        // Data wait for exactly three cycles
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle("dwait", 1, c_MEM);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("dwait_end", 1, c_IDLE);
        chk("dwait_cnt", cnt, 32'd3);
        do_reset();

        // Redirect with a fetch in flight, then squash until it returns
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("rf_take", 1, c_TAKE);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rf_sq1", 1, c_IF);
        cycle("rf_sq2", 1, c_IF);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rf_sqend", 1, c_SQEND);
        cycle("rf_run", 1, c_IDLE);
        do_reset();

        // Redirect deferred by mem_hold
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("rm_defer1", 1, c_MEM);
        cycle("rm_defer2", 1, c_MEM);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("rm_take", 1, c_TAKE);
        do_reset();

        // Saturation of the narrow counter, then reset mid-squash
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle("sat_if", 1, c_IF);
        chk("sat_cnt4", {28'd0, cnt_s}, 32'd15);
        chk("sat_cnt32", cnt, 32'd20);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("sat_take", 1, c_TAKE);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("sat_sq", 1, c_IF);
        reset = 1'b1;
        cycle("sat_rst", 1, c_RST);
        reset = 1'b0;
        chk("rst_cnt32", cnt, 32'd0);
        chk("rst_cnt4", {28'd0, cnt_s}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst_run", 1, c_IDLE);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_in(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            cycle("rand", 0, c_IDLE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage in-order pipeline. It drives the `stall` and `flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Its inputs are bus-wait conditions, load-use hazards, multi-cycle execute-unit occupancy and EX-stage branch redirects. It keeps a small state machine so that a redirect arriving while an instruction fetch is still in flight squashes the stale returning instruction. It also keeps a saturating stall-cycle counter for performance CSRs.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  input  1: single clock.
- `reset`  input  1: synchronous, active-high.
- `i_wait`  input  1: fetch request outstanding, instruction not yet returned.
- `d_wait`  input  1: MEM-stage data access outstanding.
- `ex_busy`  input  1: multi-cycle unit (mul/div) in EX not finished.
- `ex_is_load`  input  1: instruction in EX is a load.
- `ex_rd`  input  5: destination register of the EX instruction.
- `id_rs1`, `id_rs2`  input  5 each: source registers of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  input  1 each: ID instruction actually reads that source.
- `ex_redirect`  input  1: EX resolved a taken branch or jump.
- `stall_f`  output  1: hold the PC.
- `stall_d`, `stall_e`, `stall_m`, `stall_w`  output  1 each: hold the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  output  1 each: clear the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- `redirect_take`  output  1: PC unit loads the redirect target this cycle.
- `stall_cycles`  output  CNT_W: saturating count of cycles with `stall_f` high.

## Operation
Hazard terms are evaluated combinationally each cycle, highest priority first:
- **mem_hold** = `d_wait`. Asserts `stall_f/d/e/m`; `flush_w` inserts a bubble into WB.
- **ex_hold** = `ex_busy` & ~mem_hold. Asserts `stall_f/d/e`; `flush_m`.
- **lu_hold** = `ex_is_load` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)) & ~mem_hold & ~ex_hold. Asserts `stall_f/d`; `flush_e`.
- **redirect**:
  - `redirect_take` = `ex_redirect` & ~mem_hold & ~ex_hold. lu_hold never masks it.
  - On take: assert `flush_e` and `flush_d`; deassert `stall_f` and `stall_d`, overriding lu_hold.
- **if_hold** = `i_wait` & no higher hold & ~`redirect_take`. Asserts `stall_f`; `flush_d`.
- `stall_w` is tied to 0.

Invariant: for each register, stall and flush are never both 1. Flush wins inside the register, so this invariant is a hard requirement.

State machine, with states RUN and SQUASH:
- RUN → SQUASH when `redirect_take` & `i_wait`: the returning fetch is wrong-path.
- In SQUASH:
  - `stall_f` follows `i_wait`.
  - `flush_d` is 1 every cycle, so no instruction enters ID.
  - Downstream holds still apply as above.
- SQUASH → RUN on the first cycle with `i_wait`=0. `flush_d` is 1 on that cycle too, which discards the stale instruction.
- `redirect_take` while in SQUASH stays in SQUASH. The PC is already retargeted and the stale fetch is still squashed.
- `redirect_take` with `i_wait`=0 stays in RUN. The flush is a single cycle.

Counter:
- `stall_cycles` increments when `stall_f`=1.
- It saturates at all-ones and does not wrap.

Reset:
- While `reset` is high: state is RUN and `stall_cycles` is 0.
- All stall outputs are 0, all flush outputs are 1, and `redirect_take` is 0.

## Timing
- All stall, flush and `redirect_take` outputs are combinational from the current inputs plus the registered state. There are zero cycles of latency, so pipeline registers react at the next `posedge clk`.
- The state and the counter update on `posedge clk`. The SQUASH effect begins the cycle after `redirect_take`.
- Simultaneous `d_wait` and `ex_redirect`: the redirect is deferred, with `redirect_take`=0. EX is held, so the redirect is re-presented every cycle until it is taken.
- Simultaneous `ex_redirect` and lu_hold: the redirect wins, because the hazarding ID instruction is wrong-path.
- `reset` asserted while in SQUASH: the next state is RUN and the pending squash is discarded.

## Test plan
- **Load-use.** `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1. Required: one cycle of `stall_f`=`stall_d`=1 and `flush_e`=1. With `ex_rd`=0, nothing asserts.
- **Data wait.** `d_wait` high for 3 cycles. Required: `stall_f/d/e/m`=1 and `flush_w`=1 for exactly those 3 cycles, and `stall_cycles` increases by 3.
- **Redirect while fetching.** `ex_redirect` pulsed with `i_wait`=1, then `i_wait` stays high for 2 more cycles. Required: `redirect_take`=1 and `flush_e`=`flush_d`=1, then SQUASH with `flush_d`=1 on every cycle through the cycle `i_wait` drops, then RUN.
- **Redirect under mem_hold.** `ex_redirect` and `d_wait` held high together for 2 cycles, then `d_wait` drops. Required: `redirect_take`=0, 0, then 1.
- **Priority and exclusivity.** Random combinations of all inputs for 10k cycles. Required: for every register, (stall & flush)=0 in every cycle.
- **Reset and saturation.** With `CNT_W`=4, hold `i_wait` for 20 cycles. Required: `stall_cycles` reaches 15 and holds at 15. Then assert `reset` mid-SQUASH. Required: all flushes=1, counter=0, and RUN afterwards.
